// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared types and sizing helpers for the reset_sequencer block.
//   - seq_state_t : sequencer FSM states (ASSERT, RELEASE, RUN)
//   - cnt_width() : width of the stretch/gap counter
//   - idx_width() : width of the channel release index
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN
    } seq_state_t;

    // Counter must hold max(stretch, gap) without wrapping.
    function automatic int unsigned cnt_width(input int unsigned stretch_cycles,
                                              input int unsigned stage_gap);
        int unsigned max_val;
        max_val = (stretch_cycles > stage_gap) ? stretch_cycles : stage_gap;
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_channels);
        return $clog2(num_channels + 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain
//   Asynchronous-assert / synchronous-deassert reset synchroniser.
//   Ports:
//     i_clk      in  domain clock
//     i_reset    in  asynchronous active-low reset source
//     o_rst_sync out active-high synchronised reset, deasserts SYNC_STAGES
//                    edges after i_reset rises
module rst_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_rst_sync
);

    (* keep = "true" *) logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_sync = ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Synchronises an asynchronous active-low reset, stretches it to a minimum
//   width and releases NUM_CHANNELS reset outputs in order (bit 0 first),
//   spaced by STAGE_GAP cycles.
//   Ports:
//     i_clk      in   domain clock
//     i_reset    in   asynchronous active-low reset, asserts all outputs at once
//     i_soft_rst in   synchronous active-high soft-reset request
//     o_rst      out  sequenced resets, polarity set by OUT_ACTIVE_LOW
//     o_ready    out  high once every channel is released
//   Build option:
//     RESET_SEQ_SOFT_RST_EN  when defined, i_soft_rst restarts the sequence;
//                            otherwise the port is present but ignored.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGE_GAP      = 8,
    parameter int unsigned OUT_ACTIVE_LOW = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_soft_rst,
    output logic [NUM_CHANNELS-1:0] o_rst,
    output logic                    o_ready
);

    localparam int unsigned CNT_W = cnt_width(STRETCH_CYCLES, STAGE_GAP);
    localparam int unsigned IDX_W = idx_width(NUM_CHANNELS);

    localparam logic [NUM_CHANNELS-1:0] ASSERTED_VAL = (OUT_ACTIVE_LOW != 0) ? '0 : '1;
    localparam logic [CNT_W-1:0] STRETCH_TC = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC     = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX  = IDX_W'(1);

    logic                    rst_sync_raw;
    logic                    rst_sync_q;
    logic                    soft_accept;
    logic                    soft_hold;
    logic                    start;

    seq_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_CHANNELS-1:0] o_rst_q;
    logic [NUM_CHANNELS-1:0] rel_q, rel_d;
    logic                    ready_q, ready_d;

    rst_sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync_chain (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .o_rst_sync(rst_sync_raw)
    );

    // One extra flop so the last edge that sees the synchronised reset active
    // plays the same role as the last sampled soft-reset edge: channel 0 then
    // releases STRETCH_CYCLES edges later in both cases.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rst_sync_q <= 1'b1;
        end else begin
            rst_sync_q <= rst_sync_raw;
        end
    end

`ifdef RESET_SEQ_SOFT_RST_EN
    assign soft_accept = i_soft_rst && (state_q != ASSERT);
    assign soft_hold   = i_soft_rst;
`else
    logic unused_soft_rst;
    assign unused_soft_rst = i_soft_rst;
    assign soft_accept     = 1'b0;
    assign soft_hold       = 1'b0;
`endif

    assign start = rst_sync_q | soft_hold;

    // Released-channel mask, 1 = released, independent of output polarity.
    assign rel_q = o_rst_q ^ ASSERTED_VAL;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        ready_d = ready_q;

        case (state_q)
            ASSERT: begin
                rel_d   = '0;
                ready_d = 1'b0;
                idx_d   = FIRST_IDX;
                if (start) begin
                    cnt_d = '0;
                end else if (cnt_q == STRETCH_TC) begin
                    cnt_d    = '0;
                    rel_d[0] = 1'b1;
                    if (NUM_CHANNELS == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (cnt_q == GAP_TC) begin
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rel_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RUN: begin
                cnt_d = '0;
            end

            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
                idx_d   = FIRST_IDX;
                rel_d   = '0;
                ready_d = 1'b0;
            end
        endcase

        // An accepted soft reset overrides any terminal count on the same edge.
        if (soft_accept) begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = FIRST_IDX;
            rel_d   = '0;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= FIRST_IDX;
            o_rst_q <= ASSERTED_VAL;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            o_rst_q <= rel_d ^ ASSERTED_VAL;
            ready_q <= ready_d;
        end
    end

    assign o_rst   = o_rst_q;
    assign o_ready = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int SYNC_A    = 2;
    localparam int NCH_A     = 4;
    localparam int STRETCH_A = 16;
    localparam int GAP_A     = 8;

    localparam int SYNC_B    = 3;
    localparam int STRETCH_B = 1;
    localparam int GAP_B     = 8;

    typedef struct {
        int          n;
        logic [15:0] rst;
        logic        rdy;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             soft_a;
    logic             soft_b;
    logic [NCH_A-1:0] rst_a;
    logic             ready_a;
    logic [0:0]       rst_b;
    logic             ready_b;

    int   total_cnt;
    int   pass_cnt;
    exp_t sb[$];

    reset_sequencer #(
        .SYNC_STAGES   (SYNC_A),
        .NUM_CHANNELS  (NCH_A),
        .STRETCH_CYCLES(STRETCH_A),
        .STAGE_GAP     (GAP_A),
        .OUT_ACTIVE_LOW(1)
    ) dut_a (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_soft_rst(soft_a),
        .o_rst     (rst_a),
        .o_ready   (ready_a)
    );

    reset_sequencer #(
        .SYNC_STAGES   (SYNC_B),
        .NUM_CHANNELS  (1),
        .STRETCH_CYCLES(STRETCH_B),
        .STAGE_GAP     (GAP_B),
        .OUT_ACTIVE_LOW(0)
    ) dut_b (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_soft_rst(soft_b),
        .o_rst     (rst_b),
        .o_ready   (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Release schedule: channel k released on edge refe + stretch + k*gap,
    // where refe is the last edge at which the reset source was seen active.
    function automatic logic [15:0] model_rst(int n, int refe, int stretch, int gap,
                                              int nch, bit act_low);
        logic [15:0] r;
        bit          rel;
        r = '0;
        for (int k = 0; k < nch; k++) begin
            rel  = (n >= refe + stretch + k * gap);
            r[k] = act_low ? rel : !rel;
        end
        return r;
    endfunction

    function automatic logic model_rdy(int n, int refe, int stretch, int gap, int nch);
        return (n >= refe + stretch + (nch - 1) * gap);
    endfunction

    // Pulse i_reset low for five cycles; the next rising edge is edge 0.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        soft_a = 1'b0;
        soft_b = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (rst_a !== 4'b0000) $display("FAIL reset_rst_a: got %b want 0000", rst_a);
        else pass_cnt++;
        total_cnt++;
        if (ready_a !== 1'b0) $display("FAIL reset_ready_a: got %b want 0", ready_a);
        else pass_cnt++;
        total_cnt++;
        if (rst_b !== 1'b1) $display("FAIL reset_rst_b: got %b want 1", rst_b);
        else pass_cnt++;
        total_cnt++;
        if (ready_b !== 1'b0) $display("FAIL reset_ready_b: got %b want 0", ready_b);
        else pass_cnt++;
    endtask

    task automatic test_hw_sequence();
        exp_t e;
        pulse_reset();
        for (int n = 0; n <= 50; n++) begin
            sb.push_back('{n, model_rst(n, SYNC_A, STRETCH_A, GAP_A, NCH_A, 1'b1),
                          model_rdy(n, SYNC_A, STRETCH_A, GAP_A, NCH_A)});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total_cnt++;
            if ({12'b0, rst_a} !== e.rst || ready_a !== e.rdy)
                $display("FAIL hw_seq edge %0d: got rst=%b rdy=%b want rst=%b rdy=%b",
                         e.n, rst_a, ready_a, e.rst[3:0], e.rdy);
            else pass_cnt++;
        end
    endtask

    task automatic test_midseq_reset();
        exp_t e;
        pulse_reset();
        for (int n = 0; n <= 30; n++) begin
            sb.push_back('{n, model_rst(n, SYNC_A, STRETCH_A, GAP_A, NCH_A, 1'b1),
                          model_rdy(n, SYNC_A, STRETCH_A, GAP_A, NCH_A)});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total_cnt++;
            if ({12'b0, rst_a} !== e.rst || ready_a !== e.rdy)
                $display("FAIL midseq_pre edge %0d: got rst=%b rdy=%b want rst=%b rdy=%b",
                         e.n, rst_a, ready_a, e.rst[3:0], e.rdy);
            else pass_cnt++;
        end
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (rst_a !== 4'b0000 || ready_a !== 1'b0)
            $display("FAIL midseq_async: got rst=%b rdy=%b want rst=0000 rdy=0", rst_a, ready_a);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n <= 44; n++) begin
            sb.push_back('{n, model_rst(n, SYNC_A, STRETCH_A, GAP_A, NCH_A, 1'b1),
                          model_rdy(n, SYNC_A, STRETCH_A, GAP_A, NCH_A)});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total_cnt++;
            if ({12'b0, rst_a} !== e.rst || ready_a !== e.rdy)
                $display("FAIL midseq_post edge %0d: got rst=%b rdy=%b want rst=%b rdy=%b",
                         e.n, rst_a, ready_a, e.rst[3:0], e.rdy);
            else pass_cnt++;
        end
    endtask

    // Soft reset on edges [s_first, s_last]; n_max bounds the run.
    task automatic test_soft_window(input int s_first, input int s_last, input int n_max);
        exp_t e;
        int   refe;
        pulse_reset();
        for (int n = 0; n <= n_max; n++) begin
            soft_a = (n >= s_first && n <= s_last);
            refe   = SYNC_A;
`ifdef RESET_SEQ_SOFT_RST_EN
            if (n >= s_first) refe = s_last;
`endif
            sb.push_back('{n, model_rst(n, refe, STRETCH_A, GAP_A, NCH_A, 1'b1),
                          model_rdy(n, refe, STRETCH_A, GAP_A, NCH_A)});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total_cnt++;
            if ({12'b0, rst_a} !== e.rst || ready_a !== e.rdy)
                $display("FAIL soft(%0d..%0d) edge %0d: got rst=%b rdy=%b want rst=%b rdy=%b",
                         s_first, s_last, e.n, rst_a, ready_a, e.rst[3:0], e.rdy);
            else pass_cnt++;
        end
        soft_a = 1'b0;
    endtask

    task automatic test_soft_run();
        test_soft_window(100, 102, 150);
    endtask

    // Edge 34 is channel 2's terminal count in the hardware schedule.
    task automatic test_soft_terminal_count();
        test_soft_window(34, 34, 80);
    endtask

    task automatic test_single_channel();
        exp_t e;
        pulse_reset();
        for (int n = 0; n <= 8; n++) begin
            sb.push_back('{n, model_rst(n, SYNC_B, STRETCH_B, GAP_B, 1, 1'b0),
                          model_rdy(n, SYNC_B, STRETCH_B, GAP_B, 1)});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total_cnt++;
            if ({15'b0, rst_b} !== e.rst || ready_b !== e.rdy)
                $display("FAIL single edge %0d: got rst=%b rdy=%b want rst=%b rdy=%b",
                         e.n, rst_b, ready_b, e.rst[0], e.rdy);
            else pass_cnt++;
        end
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        test_reset();
        test_hw_sequence();
        test_midseq_reset();
        test_soft_run();
        test_soft_terminal_count();
        test_single_channel();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
